// File: rtl/alu_shift_unit.sv
// alu_shift_unit: multi-cycle PDP-10 style shifter (LSH/ASH/ROT and the
// double-word C variants), moving up to STEP bits per clock.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   start                 request pulse, accepted only in IDLE
//   mode                  0 LSH,1 ASH,2 ROT,3 LSHC,4 ASHC,5 ROTC (6,7 -> LSH)
//   in_high, in_low       operands (in_high used by C modes only)
//   count                 signed shift count, positive = left
//   result_high/low       working/result registers, valid at done
//   overflow              ASH/ASHC lost a significant bit
//   busy                  shifting with bits still remaining
//   done                  one-cycle completion pulse
module alu_shift_unit #(
  parameter int unsigned WIDTH  = 36,
  parameter int unsigned STEP   = 1,
  parameter int unsigned COUNTW = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [WIDTH-1:0]  in_high,
  input  logic [WIDTH-1:0]  in_low,
  input  logic [COUNTW-1:0] count,
  output logic [WIDTH-1:0]  result_high,
  output logic [WIDTH-1:0]  result_low,
  output logic              overflow,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] M_LSH  = 3'd0;
  localparam logic [2:0] M_ASH  = 3'd1;
  localparam logic [2:0] M_ROT  = 3'd2;
  localparam logic [2:0] M_LSHC = 3'd3;
  localparam logic [2:0] M_ASHC = 3'd4;
  localparam logic [2:0] M_ROTC = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state, state_nxt;
  logic [2:0]         mode_q, mode_d;
  logic               left_q, left_d;
  logic [COUNTW-1:0]  rem_q, rem_d;
  logic [COUNTW-1:0]  mag;
  logic [COUNTW-1:0]  step_k;
  logic [WIDTH-1:0]   high_d, low_d;
  logic [WIDTH-1:0]   sh_high, sh_low;
  logic               sh_ovf, ovf_d, busy_d, done_d;

  // Magnitude of the count; the most negative value maps to 2^(COUNTW-1).
  assign mag    = count[COUNTW-1] ? (COUNTW'(0) - count) : count;
  assign step_k = (rem_q > COUNTW'(STEP)) ? COUNTW'(STEP) : rem_q;

  // One RUN cycle of shifting: step_k single-bit shifts chained in sequence.
  always_comb begin
    sh_high = result_high;
    sh_low  = result_low;
    sh_ovf  = overflow;
    for (int unsigned j = 0; j < STEP; j++) begin
      if (COUNTW'(j) < step_k) begin
        case (mode_q)
          M_ASH: begin
            if (left_q) begin
              // Bit leaving the magnitude must match the sign.
              if (sh_low[WIDTH-2] != sh_low[WIDTH-1]) sh_ovf = 1'b1;
              sh_low = {sh_low[WIDTH-1], sh_low[WIDTH-3:0], 1'b0};
            end else begin
              sh_low = {sh_low[WIDTH-1], sh_low[WIDTH-1], sh_low[WIDTH-2:1]};
            end
          end
          M_ROT: begin
            if (left_q) sh_low = {sh_low[WIDTH-2:0], sh_low[WIDTH-1]};
            else        sh_low = {sh_low[0], sh_low[WIDTH-1:1]};
          end
          M_LSHC: begin
            if (left_q) {sh_high, sh_low} = {sh_high[WIDTH-2:0], sh_low, 1'b0};
            else        {sh_high, sh_low} = {1'b0, sh_high, sh_low[WIDTH-1:1]};
          end
          M_ASHC: begin
            // Both MSBs carry the high-word sign; magnitudes are WIDTH-1 bits each.
            if (left_q) begin
              if (sh_high[WIDTH-2] != sh_high[WIDTH-1]) sh_ovf = 1'b1;
              {sh_high, sh_low} = {sh_high[WIDTH-1], sh_high[WIDTH-3:0], sh_low[WIDTH-2],
                                   sh_high[WIDTH-1], sh_low[WIDTH-3:0], 1'b0};
            end else begin
              {sh_high, sh_low} = {sh_high[WIDTH-1], sh_high[WIDTH-1], sh_high[WIDTH-2:1],
                                   sh_high[WIDTH-1], sh_high[0], sh_low[WIDTH-2:1]};
            end
          end
          M_ROTC: begin
            if (left_q) {sh_high, sh_low} = {sh_high[WIDTH-2:0], sh_low, sh_high[WIDTH-1]};
            else        {sh_high, sh_low} = {sh_low[0], sh_high, sh_low[WIDTH-1:1]};
          end
          default: begin
            if (left_q) sh_low = {sh_low[WIDTH-2:0], 1'b0};
            else        sh_low = {1'b0, sh_low[WIDTH-1:1]};
          end
        endcase
      end
    end
  end

  // Next-state and register inputs.
  always_comb begin
    state_nxt = state;
    mode_d    = mode_q;
    left_d    = left_q;
    rem_d     = rem_q;
    high_d    = result_high;
    low_d     = result_low;
    ovf_d     = overflow;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode_d    = (mode > M_ROTC) ? M_LSH : mode;
          left_d    = ~count[COUNTW-1];
          rem_d     = mag;
          high_d    = in_high;
          low_d     = in_low;
          ovf_d     = 1'b0;
          busy_d    = (mag != '0);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (rem_q == '0) begin
          done_d    = 1'b1;
          state_nxt = FIN;
        end else begin
          high_d = sh_high;
          low_d  = sh_low;
          ovf_d  = sh_ovf;
          rem_d  = rem_q - step_k;
          busy_d = (rem_d != '0);
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= M_LSH;
      left_q      <= 1'b0;
      rem_q       <= '0;
      result_high <= '0;
      result_low  <= '0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      mode_q      <= mode_d;
      left_q      <= left_d;
      rem_q       <= rem_d;
      result_high <= high_d;
      result_low  <= low_d;
      overflow    <= ovf_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_shift_unit.sv
// Bench for alu_shift_unit: STEP=1 and STEP=4 instances, table vectors,
// model-driven random operations, and handshake/reset corner sequences.
module tb_alu_shift_unit;

  localparam logic [2:0] LSH = 3'd0, ASH = 3'd1, ROT = 3'd2,
                         LSHC = 3'd3, ASHC = 3'd4, ROTC = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start4;
  logic [2:0]  mode;
  logic [35:0] in_high, in_low;
  logic [8:0]  count;
  logic [35:0] r1h, r1l, r4h, r4l;
  logic        ov1, busy1, done1, ov4, busy4, done4;

  always #5 clk = ~clk;

  alu_shift_unit #(.WIDTH(36), .STEP(1), .COUNTW(9)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode),
    .in_high(in_high), .in_low(in_low), .count(count),
    .result_high(r1h), .result_low(r1l), .overflow(ov1), .busy(busy1), .done(done1));

  alu_shift_unit #(.WIDTH(36), .STEP(4), .COUNTW(9)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode),
    .in_high(in_high), .in_low(in_low), .count(count),
    .result_high(r4h), .result_low(r4l), .overflow(ov4), .busy(busy4), .done(done4));

  typedef struct {
    logic [35:0] h, l;
    logic        ov;
    int          lat, bsy, t0;
  } exp_t;

  typedef struct {
    logic [2:0]  m;
    logic [35:0] h, l;
    logic [8:0]  c;
    logic [35:0] eh, el;
    logic        eo;
  } vec_t;

  exp_t q1[$], q4[$];
  exp_t e1, e4;
  vec_t tab[16];
  int   passed = 0, total = 0, cyc = 0;
  int   bcnt1 = 0, bcnt4 = 0, dcnt1 = 0, dcnt4 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: whole-count shift computed directly on wide vectors.
  function automatic void model(input logic [2:0] m, input logic [35:0] h, input logic [35:0] l,
                                input logic [8:0] c, output logic [35:0] rh,
                                output logic [35:0] rl, output logic ro);
    int n, r;
    logic left, s;
    logic [71:0] v, t72v;
    logic [143:0] t;
    logic [326:0] wide, outb, mask;
    logic [69:0] mg, ng;
    logic signed [70:0] e;
    left = !c[8];
    n  = c[8] ? 512 - int'(c) : int'(c);
    rh = h; rl = l; ro = 1'b0; v = {h, l};
    if (n == 0) return;
    mask = (327'(1) << n) - 327'(1);
    case (m)
      ASH: begin
        s = l[35];
        if (left) begin
          wide = 327'(l[34:0]) << n;
          outb = wide >> 35;
          rl   = {s, wide[34:0]};
          ro   = s ? (outb != mask) : (outb != '0);
        end else rl = $signed(l) >>> n;
      end
      ROT: begin
        r = n % 36; t72v = {l, l};
        rl = left ? 36'(t72v >> (36 - r)) : 36'(t72v >> r);
      end
      LSHC: begin
        v = left ? v << n : v >> n;
        rh = v[71:36]; rl = v[35:0];
      end
      ASHC: begin
        s = h[35]; mg = {h[34:0], l[34:0]};
        if (left) begin
          wide = 327'(mg) << n;
          outb = wide >> 70;
          ng   = wide[69:0];
          ro   = s ? (outb != mask) : (outb != '0);
        end else begin
          e  = $signed({s, mg}) >>> n;
          ng = e[69:0];
        end
        rh = {s, ng[69:35]}; rl = {s, ng[34:0]};
      end
      ROTC: begin
        r = n % 72; t = {v, v};
        v = left ? 72'(t >> (72 - r)) : 72'(t >> r);
        rh = v[71:36]; rl = v[35:0];
      end
      default: rl = left ? l << n : l >> n;
    endcase
  endfunction

  // Scoreboard monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (reset) bcnt1 = 0;
    else begin
      if (busy1) bcnt1++;
      if (done1) begin
        dcnt1++;
        check("dut1 done expected", 72'(q1.size() != 0), 72'(1));
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          check("dut1 result", {r1h, r1l}, {e1.h, e1.l});
          check("dut1 overflow", 72'(ov1), 72'(e1.ov));
          check("dut1 latency", 72'(cyc - e1.t0), 72'(e1.lat));
          check("dut1 busy cycles", 72'(bcnt1), 72'(e1.bsy));
        end
        bcnt1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) bcnt4 = 0;
    else begin
      if (busy4) bcnt4++;
      if (done4) begin
        dcnt4++;
        check("dut4 done expected", 72'(q4.size() != 0), 72'(1));
        if (q4.size() != 0) begin
          e4 = q4.pop_front();
          check("dut4 result", {r4h, r4l}, {e4.h, e4.l});
          check("dut4 overflow", 72'(ov4), 72'(e4.ov));
          check("dut4 latency", 72'(cyc - e4.t0), 72'(e4.lat));
          check("dut4 busy cycles", 72'(bcnt4), 72'(e4.bsy));
        end
        bcnt4 = 0;
      end
    end
  end

  task automatic scramble();
    in_high = {4'($urandom), $urandom};
    in_low  = {4'($urandom), $urandom};
    count   = 9'($urandom);
    mode    = 3'($urandom);
  endtask

  // Pulse start on one instance and push the expected completion.
  task automatic issue(input bit d4, input logic [2:0] m, input logic [35:0] h,
                       input logic [35:0] l, input logic [8:0] c,
                       input logic [35:0] eh, input logic [35:0] el, input logic eo);
    exp_t e;
    int n, st;
    st = d4 ? 4 : 1;
    n  = c[8] ? 512 - int'(c) : int'(c);
    @(posedge clk); #1;
    mode = m; in_high = h; in_low = l; count = c;
    if (d4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    e.h = eh; e.l = el; e.ov = eo;
    e.bsy = (n + st - 1) / st;
    e.lat = e.bsy + 1;
    e.t0  = cyc;
    if (d4) q4.push_back(e); else q1.push_back(e);
    scramble();
  endtask

  task automatic issue_model(input bit d4, input logic [2:0] m, input logic [35:0] h,
                             input logic [35:0] l, input logic [8:0] c);
    logic [35:0] eh, el;
    logic eo;
    model(m, h, l, c, eh, el, eo);
    issue(d4, m, h, l, c, eh, el, eo);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (q1.size() + q4.size()) > 0; i++) @(posedge clk);
    check("drain within bound", 72'(q1.size() + q4.size()), 72'(0));
    q1.delete(); q4.delete();
  endtask

  initial begin
    int d0;
    logic [2:0] rm;
    logic [8:0] rc;
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
    mode = '0; in_high = '0; in_low = '0; count = '0;
    tab[0]  = '{LSH,  36'o123, 36'o000004000000, 9'd1, 36'o123, 36'o000010000000, 1'b0};
    tab[1]  = '{LSH,  36'o0, 36'o000004000000, 9'h1F8, 36'o0, 36'o000000010000, 1'b0};
    tab[2]  = '{ASH,  36'o0, 36'o377777777777, 9'd1, 36'o0, 36'o377777777776, 1'b1};
    tab[3]  = '{ASH,  36'o0, 36'o400000000000, 9'h1FF, 36'o0, 36'o600000000000, 1'b0};
    tab[4]  = '{ROTC, 36'o400000000000, 36'o0, 9'd1, 36'o0, 36'o000000000001, 1'b0};
    tab[5]  = '{ASHC, 36'o0, 36'o000000000001, 9'd35, 36'o000000000001, 36'o0, 1'b0};
    tab[6]  = '{ROT,  36'o1, 36'o123456701234, 9'd0, 36'o1, 36'o123456701234, 1'b0};
    tab[7]  = '{LSH,  36'o55, 36'o777777777777, 9'd36, 36'o55, 36'o0, 1'b0};
    tab[8]  = '{LSHC, 36'o777777777777, 36'o777777777777, 9'h100, 36'o0, 36'o0, 1'b0};
    tab[9]  = '{ASH,  36'o0, 36'o400000000000, 9'h100, 36'o0, 36'o777777777777, 1'b0};
    tab[10] = '{ROT,  36'o0, 36'o123456701234, 9'd36, 36'o0, 36'o123456701234, 1'b0};
    tab[11] = '{3'd7, 36'o0, 36'o000000000001, 9'd3, 36'o0, 36'o000000000010, 1'b0};
    tab[12] = '{ROTC, 36'o0, 36'o000000000001, 9'h1FF, 36'o400000000000, 36'o0, 1'b0};
    tab[13] = '{ASHC, 36'o400000000000, 36'o000000000001, 9'h1FF, 36'o600000000000, 36'o400000000000, 1'b0};
    tab[14] = '{ASH,  36'o0, 36'o200000000000, 9'd2, 36'o0, 36'o0, 1'b1};
    tab[15] = '{ROT,  36'o0, 36'o400000000001, 9'd1, 36'o0, 36'o000000000003, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset results", {r1h, r1l}, 72'(0));
    check("reset flags", 72'({ov1, busy1, done1, ov4, busy4, done4}), 72'(0));
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      issue(1'b0, tab[i].m, tab[i].h, tab[i].l, tab[i].c, tab[i].eh, tab[i].el, tab[i].eo);
      drain();
      issue(1'b1, tab[i].m, tab[i].h, tab[i].l, tab[i].c, tab[i].eh, tab[i].el, tab[i].eo);
      drain();
    end

    for (int i = 0; i < 30; i++) begin
      rm = 3'($urandom_range(0, 7));
      rc = (i % 5 == 0) ? 9'($urandom) : 9'($urandom_range(0, 80) - 40);
      in_high = {4'($urandom), $urandom};
      in_low  = {4'($urandom), $urandom};
      issue_model(i[0], rm, in_high, in_low, rc);
      drain();
    end

    // Second start during RUN is ignored; one done at 21 cycles; result holds.
    d0 = dcnt1;
    issue(1'b0, LSH, 36'o7, 36'o1, 9'd20, 36'o7, 36'o000004000000, 1'b0);
    repeat (3) @(posedge clk);
    #1 start1 = 1'b1; mode = ROT; in_low = 36'o777; count = 9'd2;
    @(posedge clk); #1 start1 = 1'b0;
    drain();
    repeat (30) @(posedge clk);
    #1;
    check("single done", 72'(dcnt1 - d0), 72'(1));
    check("result held", {r1h, r1l}, {36'o7, 36'o000004000000});

    // Reset during RUN aborts at once.
    issue(1'b0, ROT, 36'o3, 36'o123456701234, 9'd20, 36'o0, 36'o0, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort results", {r1h, r1l}, 72'(0));
    check("abort flags", 72'({ov1, busy1, done1}), 72'(0));
    q1.delete();
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start1 = 1'b0;
    @(posedge clk); #1;
    check("start under reset ignored", 72'({busy1, done1}), 72'(0));
    d0 = dcnt1;
    issue_model(1'b0, ROT, 36'o1, 36'o400000000007, 9'd20);
    drain();
    check("post-reset op done", 72'(dcnt1 - d0), 72'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_shift_unit.md
Name: alu_shift_unit

Overview:
- Multi-cycle barrel-less shifter for the KV10 ALU datapath. Replaces the single-word 1-bit-per-cycle LSH path.
- Supports six PDP-10 shift modes on single words and on double words (high,low).
- Shifts STEP bits per cycle under a start/busy/done handshake.
- The ALU's busy output is taken from this block's busy when a shift command is active.

Parameters:
- WIDTH, 36, word width in bits; doubleword is 2*WIDTH.
- STEP, 1, maximum bits shifted per clock; power of two, 1..8.
- COUNTW, 9, width of the signed shift-count field (two's complement; positive = left, negative = right).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; accepted only while idle (busy=0).
- mode  input  3  0 LSH, 1 ASH, 2 ROT, 3 LSHC, 4 ASHC, 5 ROTC; 6 and 7 reserved, treated as LSH.
- in_high  input  WIDTH  high word; used only by the C modes.
- in_low  input  WIDTH  single-word operand, or low word for the C modes.
- count  input  COUNTW  signed shift count.
- result_high  output  WIDTH  high result; holds in_high unchanged for single-word modes.
- result_low  output  WIDTH  single-word result, or low word for the C modes.
- overflow  output  1  ASH/ASHC lost a significant bit; 0 for all other modes.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid from this cycle.

Behaviour:
- Reset (async): state IDLE; result_high, result_low, overflow, busy, done all 0; internal count register 0.
- States:
  - IDLE: on start, latch mode, operands, dir = count sign and rem = |count|; overflow cleared; go to RUN.
  - RUN: busy=1. Each cycle shift by k = min(STEP, rem), then rem -= k. When rem reaches 0 after the shift, or rem=0 on entry, go to FIN.
  - FIN: busy=0, done=1 for exactly one cycle; then IDLE.
- Latency: done asserts ceil(|count|/STEP)+1 cycles after the start edge. count=0 gives done 1 cycle after start, with results equal to the inputs.
- busy rises the cycle after start acceptance.
- start while busy or in FIN is ignored; latched operands are not disturbed.
- Inputs are sampled only at acceptance; the bench may change them afterwards.
- Results are held stable from FIN until the next accepted start. They update every RUN cycle (intermediate values visible) and are valid only at done.
- Counts are not reduced modulo the width.
  - Counts with magnitude ≥ WIDTH (single) or ≥ 2*WIDTH (C modes) give all-zero results for LSH/LSHC.
  - ASH/ASHC saturate to sign fill.
  - ROT/ROTC run the full count of cycles.
  - Most-negative count = 2^(COUNTW-1) shifts right that many bits.
- Per-mode rules:
  - LSH: zeros shifted in at either end.
  - ROT: bits leaving one end enter the other.
  - LSHC: in_high:in_low shifted as one 2*WIDTH vector with zero fill.
  - ROTC: 2*WIDTH rotate; high MSB enters low LSB on left shifts.
  - ASH left: sign bit (MSB) fixed, zeros enter the LSB. overflow is set, and stays set through FIN, if any bit shifted out of bit WIDTH-2 differs from the sign.
  - ASH right: sign replicated into the MSB-1 position; overflow never set.
  - ASHC: magnitude is in_high[WIDTH-2:0]:in_low[WIDTH-2:0] (2*WIDTH-2 bits), shifted as for ASH. Both result MSBs equal the original in_high sign; in_low's MSB input is ignored. Overflow rule as ASH.
- Reset mid-RUN aborts immediately and returns to the reset state; no done is issued.
- start coincident with reset deassertion is ignored if reset is still sampled high.

Test Plan:
1. STEP=1, LSH, in_low=000004_000000(o), count=1 → result_low=000010_000000, done 2 cycles after start, busy high 1 cycle.
2. LSH, in_low=000004_000000, count=-8 → result_low=000000_010000, done after 9 cycles. Repeat with STEP=4 → same result, done after 3 cycles.
3. ASH, in_low=377777_777777, count=1 → result_low=377777_777776, overflow=1. ASH, in_low=400000_000000, count=-1 → 600000_000000, overflow=0.
4. ROTC, in_high=400000_000000, in_low=0, count=1 → result_high=0, result_low=000000_000001. ASHC, in_high=0, in_low=000000_000001, count=35 → result_high=000000_000001, result_low=0.
5. count=0, any mode → done 1 cycle after start, results=inputs. A second start pulsed during RUN of a count=20 LSH → ignored, with exactly one done at cycle 21.
6. Assert reset at cycle 5 of a count=20 ROT → busy, done and results are 0 immediately. A new start after release completes normally.
